// File: rtl/wallace_dot_acc_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state encoding
// and the product width used by the upstream 4x4 Wallace multiplier.
package wallace_dot_acc_pkg;

    localparam int PROD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/wallace_dot_acc_add.sv
// Accumulator adder: zero-extends the product, reports carry-out of the top bit.
// WALLACE_DOT_ACC_SAT_EN selects clamp-to-max instead of modulo wrap.
module wallace_dot_acc_add
    import wallace_dot_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_s;

    // Unsigned add with one extra bit to expose the carry-out.
    always_comb begin
        wide_s = {1'b0, acc} + (ACC_W + 1)'(prod);
        carry  = wide_s[ACC_W];
`ifdef WALLACE_DOT_ACC_SAT_EN
        // Once clamped, any later non-zero term carries again, so the clamp sticks.
        if (wide_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
`else
        sum = wide_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/wallace_dot_acc.sv
// Dot-product accumulator: sums a packet of multiplier products into one held result.
// Optional macro WALLACE_DOT_ACC_SAT_EN saturates the sum on overflow instead of wrapping.
module wallace_dot_acc
    import wallace_dot_acc_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_forced
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             accept;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] count_nxt;

    assign in_ready  = (state != ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};

    wallace_dot_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc    (acc),
        .prod   (in_prod),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Packet FSM, running accumulator and the held result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= {ACC_W{1'b0}};
            count      <= {CNT_W{1'b0}};
            ovf        <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= {ACC_W{1'b0}};
            out_count  <= {CNT_W{1'b0}};
            out_ovf    <= 1'b0;
            out_forced <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= ACC_W'(in_prod);
                        count <= {{(CNT_W-1){1'b0}}, 1'b1};
                        ovf   <= 1'b0;
                        if (in_last || (MAX_TERMS == 1)) begin
                            state      <= ST_HOLD;
                            out_valid  <= 1'b1;
                            out_sum    <= ACC_W'(in_prod);
                            out_count  <= {{(CNT_W-1){1'b0}}, 1'b1};
                            out_ovf    <= 1'b0;
                            out_forced <= ~in_last;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        acc   <= add_sum;
                        count <= count_nxt;
                        ovf   <= ovf | add_carry;
                        if (in_last || (count_nxt == MAX_CNT)) begin
                            state      <= ST_HOLD;
                            out_valid  <= 1'b1;
                            out_sum    <= add_sum;
                            out_count  <= count_nxt;
                            out_ovf    <= ovf | add_carry;
                            out_forced <= ~in_last;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_dot_acc.sv
// Directed bench for wallace_dot_acc (ACC_W=10, MAX_TERMS=8) with a reference
// model feeding an expected-result queue; results are popped on each output handshake.
module tb_wallace_dot_acc;

    localparam int PW   = 8;
    localparam int AW   = 10;
    localparam int MAXT = 8;
    localparam int CW   = $clog2(MAXT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          out_forced;

    typedef struct {
        int sum;
        int count;
        int ovf;
        int forced;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc  = 0;
    int   m_cnt  = 0;
    int   m_ovf  = 0;

    wallace_dot_acc #(
        .PROD_W    (PW),
        .ACC_W     (AW),
        .MAX_TERMS (MAXT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .out_forced (out_forced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model step for one accepted beat; pushes the result on closure.
    task automatic model_beat(input int prod, input bit last);
        exp_t e;
        if (m_cnt == 0) begin
            m_acc = prod;
            m_cnt = 1;
            m_ovf = 0;
        end else begin
            int t;
            t = m_acc + prod;
            m_cnt++;
            if (t > (1 << AW) - 1) begin
                m_ovf = 1;
`ifdef WALLACE_DOT_ACC_SAT_EN
                m_acc = (1 << AW) - 1;
`else
                m_acc = t % (1 << AW);
`endif
            end else begin
                m_acc = t;
            end
        end
        if (last || m_cnt == MAXT) begin
            e.sum    = m_acc;
            e.count  = m_cnt;
            e.ovf    = m_ovf;
            e.forced = (!last) ? 1 : 0;
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endtask

    // Drives one beat (called 1ns after a rising edge); waited = cycles spent stalled.
    task automatic send_beat(input int prod, input bit last, output int waited);
        bit closes;
        waited   = 0;
        in_valid = 1'b1;
        in_prod  = PW'(prod);
        in_last  = last;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        closes = last || (m_cnt + 1 == MAXT);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_beat(prod, last);
        if (closes) begin
            check("valid_after_close", {31'd0, out_valid}, 32'd1);
            check("ready_low_in_hold", {31'd0, in_ready}, 32'd0);
        end
    endtask

    // Scoreboard: every output handshake is compared with the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            check("result_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_count", 32'(out_count), 32'(e.count));
                check("out_ovf", {31'd0, out_ovf}, 32'(e.ovf));
                check("out_forced", {31'd0, out_forced}, 32'(e.forced));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_flags", {30'd0, out_ovf, out_forced}, 32'd0);
        rst = 1'b0;

        // Reset mid-packet discards the partial sum.
        send_beat(10, 1'b0, w);
        send_beat(20, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cnt = 0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        send_beat(7, 1'b1, w);
        @(posedge clk);
        #1;

        // Four-term packet, then the bubble cycle ends.
        send_beat(225, 1'b0, w);
        send_beat(1, 1'b0, w);
        send_beat(0, 1'b0, w);
        send_beat(100, 1'b1, w);
        @(posedge clk);
        #1;
        check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
        check("bubble_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: result held while a new beat waits.
        out_ready = 1'b0;
        send_beat(5, 1'b0, w);
        send_beat(6, 1'b1, w);
        in_valid = 1'b1;
        in_prod  = 8'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'd11);
            check("bp_out_count", 32'(out_count), 32'd2);
        end
        out_ready = 1'b1;
        send_beat(99, 1'b1, w);
        check("bp_release_wait", 32'(w), 32'd1);
        @(posedge clk);
        #1;

        // Forced close at MAX_TERMS; the next term opens a new packet.
        for (int i = 0; i < MAXT; i++) begin
            send_beat(3, 1'b0, w);
        end
        @(posedge clk);
        #1;
        send_beat(3, 1'b1, w);
        @(posedge clk);
        #1;

        // in_last on exactly the MAX_TERMS-th term is not a forced close.
        for (int i = 0; i < MAXT; i++) begin
            send_beat(2, (i == MAXT - 1), w);
        end
        @(posedge clk);
        #1;

        // Overflow: 5 x 225 exceeds 1023.
        for (int i = 0; i < 5; i++) begin
            send_beat(225, (i == 4), w);
        end
        @(posedge clk);
        #1;

        // End-to-end with multiplier products 15*15, 3*5, 0*9.
        send_beat(15 * 15, 1'b0, w);
        send_beat(3 * 5, 1'b0, w);
        send_beat(0 * 9, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
